// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: round-robin pixel writes from the ray-marcher cores
// and double-buffer frame sequencing locked to the display vsync.
`ifndef ADDR_BITS
`define ADDR_BITS 17
`endif
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 240
`endif

module fb_write_arbiter #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_BITS  = `ADDR_BITS,
    parameter int DATA_BITS  = 4,
    parameter int NUM_PIXELS = `DISPLAY_WIDTH * `DISPLAY_HEIGHT
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [NUM_CORES-1:0]           req_valid_in,
    input  logic [NUM_CORES*ADDR_BITS-1:0] req_addr_in,
    input  logic [NUM_CORES*DATA_BITS-1:0] req_data_in,
    output logic [NUM_CORES-1:0]           req_ready_out,
    input  logic                           render_done_in,
    input  logic                           vsync_in,
    output logic                           render_start_out,
    output logic                           wr_en_out,
    output logic [ADDR_BITS:0]             wr_addr_out,
    output logic [DATA_BITS-1:0]           wr_data_out,
    output logic                           disp_buf_out,
    output logic [7:0]                     frame_count_out,
    output logic                           oob_out
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RENDER,
        ST_WAIT_VSYNC
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic                 wr_buf_q, wr_buf_d;
    logic                 vsync_prev_q;
    logic [7:0]           frame_count_q, frame_count_d;
    logic                 oob_q, oob_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_BITS:0]   wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;

    logic [ADDR_BITS-1:0] core_addr [NUM_CORES];
    logic [DATA_BITS-1:0] core_data [NUM_CORES];

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
        assign core_addr[g] = req_addr_in[g*ADDR_BITS +: ADDR_BITS];
        assign core_data[g] = req_data_in[g*DATA_BITS +: DATA_BITS];
    end

    logic                 grant_found;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     cand_idx;
    int                   cand;
    logic                 handshake;
    logic [ADDR_BITS-1:0] grant_addr;
    logic [DATA_BITS-1:0] grant_data;
    logic                 addr_in_range;
    logic                 vsync_fall;

    // Scan from ptr upward with wrap; only valid bits matter, never addr/data.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_CORES) begin
                cand = cand - NUM_CORES;
            end
            cand_idx = PTR_W'(cand);
            if (!grant_found && req_valid_in[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign handshake     = (state_q == ST_RENDER) && grant_found;
    assign grant_addr    = core_addr[grant_idx];
    assign grant_data    = core_data[grant_idx];
    assign addr_in_range = (32'(grant_addr) < NUM_PIXELS);
    assign vsync_fall    = vsync_prev_q && !vsync_in;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        wr_buf_d      = wr_buf_q;
        frame_count_d = frame_count_q;
        oob_d         = oob_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_RENDER;
            end
            ST_RENDER: begin
                if (handshake) begin
                    ptr_d = (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + PTR_W'(1);
                    if (addr_in_range) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {wr_buf_q, grant_addr};
                        wr_data_d = grant_data;
                    end else begin
                        oob_d = 1'b1;
                    end
                end
                if (render_done_in) begin
                    state_d = ST_WAIT_VSYNC;
                end
            end
            ST_WAIT_VSYNC: begin
                if (vsync_fall) begin
                    state_d       = ST_IDLE;
                    wr_buf_d      = ~wr_buf_q;
                    frame_count_d = frame_count_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register stage: control and the single write-port pipeline stage.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            wr_buf_q      <= 1'b0;
            vsync_prev_q  <= 1'b1;
            frame_count_q <= 8'd0;
            oob_q         <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            wr_buf_q      <= wr_buf_d;
            vsync_prev_q  <= vsync_in;
            frame_count_q <= frame_count_d;
            oob_q         <= oob_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign req_ready_out    = handshake ? (NUM_CORES'(1) << grant_idx) : '0;
    assign render_start_out = (state_q == ST_IDLE) && !rst_in;
    assign wr_en_out        = wr_en_q;
    assign wr_addr_out      = wr_addr_q;
    assign wr_data_out      = wr_data_q;
    assign disp_buf_out     = ~wr_buf_q;
    assign frame_count_out  = frame_count_q;
    assign oob_out          = oob_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized scoreboard bench for fb_write_arbiter: a frame-level reference model
// predicts grants, writes and frame bookkeeping; a monitor checks the write port.
module tb_fb_write_arbiter;

    localparam int N  = 4;
    localparam int AB = 8;
    localparam int DB = 4;
    localparam int NP = 200;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AB-1:0] req_addr;
    logic [N*DB-1:0] req_data;
    logic [N-1:0]    ready;
    logic            render_done;
    logic            vsync;
    logic            render_start;
    logic            wr_en;
    logic [AB:0]     wr_addr;
    logic [DB-1:0]   wr_data;
    logic            disp_buf;
    logic [7:0]      frame_count;
    logic            oob;

    always #5 clk = ~clk;

    fb_write_arbiter #(
        .NUM_CORES (N),
        .ADDR_BITS (AB),
        .DATA_BITS (DB),
        .NUM_PIXELS(NP)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .req_valid_in    (req_valid),
        .req_addr_in     (req_addr),
        .req_data_in     (req_data),
        .req_ready_out   (ready),
        .render_done_in  (render_done),
        .vsync_in        (vsync),
        .render_start_out(render_start),
        .wr_en_out       (wr_en),
        .wr_addr_out     (wr_addr),
        .wr_data_out     (wr_data),
        .disp_buf_out    (disp_buf),
        .frame_count_out (frame_count),
        .oob_out         (oob)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [AB:0]   addr;
        logic [DB-1:0] data;
        int            due;
    } wr_t;

    wr_t sbq[$];
    int  ncyc = 0;

    always @(posedge clk) ncyc <= ncyc + 1;

    // Reference model: frame stage 0 = start pulse, 1 = rendering, 2 = waiting for vsync.
    int           m_stage = 0;
    int           m_ptr   = 0;
    int           m_cnt   = 0;
    bit           m_buf   = 1'b0;
    bit           m_vprev = 1'b1;
    bit           m_oob   = 1'b0;
    bit           m_ok    = 1'b0;
    logic [N-1:0] m_hs    = '0;

    bit           cv    [N];
    logic [AB-1:0] caddr [N];
    logic [DB-1:0] cdata [N];
    bit           forced[N];

    // Winner is the valid core at the smallest circular distance from the pointer.
    function automatic int pick_core();
        int best, bestd, d;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (cv[i]) begin
                d = (i - m_ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    always @(negedge clk) begin
        int  best;
        wr_t e;
        best = pick_core();
        if (m_ok) begin
            chk("render_start", 32'(render_start), 32'(m_stage == 0 && !rst));
            if (!rst) begin
                chk("ready", 32'(ready), (m_stage == 1 && best >= 0) ? (32'd1 << best) : 32'd0);
            end
            chk("disp_buf", 32'(disp_buf), 32'(!m_buf));
            chk("frame_count", 32'(frame_count), 32'(m_cnt));
            chk("oob", 32'(oob), 32'(m_oob));
        end
        m_hs = '0;
        if (rst) begin
            m_stage = 0;
            m_ptr   = 0;
            m_cnt   = 0;
            m_buf   = 1'b0;
            m_vprev = 1'b1;
            m_oob   = 1'b0;
            m_ok    = 1'b1;
        end else begin
            if (m_stage == 0) begin
                m_stage = 1;
            end else if (m_stage == 1) begin
                if (best >= 0) begin
                    m_hs[best] = 1'b1;
                    m_ptr = (best + 1) % N;
                    if (int'(caddr[best]) < NP) begin
                        e.addr = {m_buf, caddr[best]};
                        e.data = cdata[best];
                        e.due  = ncyc + 1;
                        sbq.push_back(e);
                    end else begin
                        m_oob = 1'b1;
                    end
                end
                if (render_done) m_stage = 2;
            end else begin
                if (m_vprev && !vsync) begin
                    m_stage = 0;
                    m_buf   = !m_buf;
                    m_cnt   = (m_cnt + 1) % 256;
                end
            end
            m_vprev = vsync;
        end
    end

    // Monitor: pops the scoreboard whenever the write port presents a write.
    bit            mon_ok = 1'b0;
    logic [AB:0]   hold_a = '0;
    logic [DB-1:0] hold_d = '0;

    always @(negedge clk) begin
        wr_t e;
        if (mon_ok) begin
            if (wr_en) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write at %0t",
                             wr_addr, wr_data, $time);
                end else begin
                    e = sbq.pop_front();
                    chk("wr_latency", 32'(ncyc), 32'(e.due));
                    chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                    chk("wr_data", 32'(wr_data), 32'(e.data));
                    hold_a = e.addr;
                    hold_d = e.data;
                end
            end else begin
                if (sbq.size() > 0 && sbq[0].due <= ncyc) begin
                    checks++;
                    failures++;
                    $display("FAIL missing_write: got wr_en 0 expected addr %0h data %0h at %0t",
                             sbq[0].addr, sbq[0].data, $time);
                    sbq.delete(0);
                end
                chk("hold_addr", 32'(wr_addr), 32'(hold_a));
                chk("hold_data", 32'(wr_data), 32'(hold_d));
            end
        end
        if (rst) begin
            mon_ok = 1'b1;
            hold_a = '0;
            hold_d = '0;
        end
    end

    function automatic logic [AB-1:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return AB'($urandom_range(NP, (1 << AB) - 1));
        return AB'($urandom_range(0, NP - 1));
    endfunction

    task automatic set_core(input int i, input int a, input int d);
        cv[i]     = 1'b1;
        caddr[i]  = AB'(a);
        cdata[i]  = DB'(d);
        forced[i] = 1'b1;
    endtask

    // A core re-requests only after its previous request was accepted.
    task automatic drive(input bit done, input bit vs, input bit r, input int p);
        for (int i = 0; i < N; i++) begin
            if (forced[i]) begin
                forced[i] = 1'b0;
            end else if (m_hs[i] || !cv[i]) begin
                cv[i]    = ($urandom_range(0, 99) < p);
                caddr[i] = rand_addr();
                cdata[i] = DB'($urandom_range(0, 15));
            end
            req_valid[i]          = cv[i];
            req_addr[i*AB +: AB]  = caddr[i];
            req_data[i*DB +: DB]  = cdata[i];
        end
        render_done = done;
        vsync       = vs;
        rst         = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit vs;
        for (int i = 0; i < N; i++) begin
            cv[i] = 1'b0; caddr[i] = '0; cdata[i] = '0; forced[i] = 1'b0;
        end
        rst = 1'b1; render_done = 1'b0; vsync = 1'b1;
        req_valid = '0; req_addr = '0; req_data = '0;

        repeat (3) drive(1'b0, 1'b1, 1'b1, 0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);

        set_core(0, 5, 4'hA);
        repeat (4) drive(1'b0, 1'b1, 1'b0, 0);

        repeat (8) drive(1'b0, 1'b1, 1'b0, 100);
        repeat (5) drive(1'b0, 1'b1, 1'b0, 0);

        set_core(2, 10, 3);
        repeat (2) drive(1'b0, 1'b1, 1'b0, 0);
        set_core(2, 11, 4);
        repeat (2) drive(1'b0, 1'b1, 1'b0, 0);

        set_core(1, NP - 1, 7);
        repeat (2) drive(1'b0, 1'b1, 1'b0, 0);
        set_core(1, NP, 8);
        repeat (2) drive(1'b0, 1'b1, 1'b0, 0);
        set_core(3, 20, 9);
        repeat (2) drive(1'b0, 1'b1, 1'b0, 0);

        repeat (150) drive(1'b0, 1'b1, 1'b0, 60);

        drive(1'b1, 1'b1, 1'b0, 100);
        repeat (10) drive(1'b0, 1'b1, 1'b0, 60);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 60);
        repeat (20) drive(1'b0, 1'b1, 1'b0, 60);

        drive(1'b1, 1'b0, 1'b0, 50);
        repeat (5) drive(1'b0, 1'b0, 1'b0, 50);
        drive(1'b0, 1'b1, 1'b0, 50);
        repeat (10) drive(1'b0, 1'b0, 1'b0, 50);

        drive(1'b1, 1'b1, 1'b0, 50);
        repeat (3) drive(1'b0, 1'b1, 1'b0, 50);
        repeat (2) drive(1'b0, 1'b1, 1'b1, 50);
        repeat (10) drive(1'b0, 1'b1, 1'b0, 50);

        for (int s = 0; s < 256; s++) begin
            drive(1'b1, 1'b1, 1'b0, 30);
            drive(1'b0, 1'b0, 1'b0, 30);
            repeat (2) drive(1'b0, 1'b1, 1'b0, 30);
        end
        chk("frame_count_wrap", 32'(frame_count), 32'd0);

        vs = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 7) == 0) vs = !vs;
            drive($urandom_range(0, 19) == 0, vs, $urandom_range(0, 499) == 0, 50);
        end

        repeat (8) drive(1'b0, 1'b1, 1'b0, 0);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
